// File: rtl/fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// fifo_uart_tx
//
// Purpose:
//    UART transmitter that drains a show-ahead FIFO. Each frame is one start
//    bit (0), g_WIDTH data bits sent LSB first, and one stop bit (1). Every
//    bit is held for g_CLKS_PER_BIT clock cycles. A word is popped either
//    while idle or on the final cycle of a stop bit. That second case lets
//    frames run back-to-back with no idle gap between them.
//
// Parameters:
//    g_WIDTH        - data bits per frame (5..9)
//    g_CLKS_PER_BIT - i_clk cycles per serial bit period (>= 2)
//
// Ports:
//    i_clk          - single clock, rising-edge active
//    i_rst          - asynchronous, active-high reset
//    i_enable       - permits new frames to start while high
//    i_fifo_empty   - upstream FIFO empty flag
//    i_fifo_rd_data - upstream FIFO head word (valid while not empty)
//    o_fifo_rd_en   - pops one FIFO word in each cycle it is high
//    o_tx_serial    - registered UART line, idle-high
//    o_tx_active    - registered, high while a frame is on the line
//    o_tx_done      - registered, one-cycle pulse on the last stop-bit cycle
// ---------------------------------------------------------------------------
module fifo_uart_tx #(
   parameter int g_WIDTH        = 8,
   parameter int g_CLKS_PER_BIT = 87
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_enable,
   input  logic               i_fifo_empty,
   input  logic [g_WIDTH-1:0] i_fifo_rd_data,
   output logic               o_fifo_rd_en,
   output logic               o_tx_serial,
   output logic               o_tx_active,
   output logic               o_tx_done
);

   localparam int CNT_W = $clog2(g_CLKS_PER_BIT);
   localparam int IDX_W = $clog2(g_WIDTH);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(g_CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = '0;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(g_WIDTH - 1);
   localparam logic [IDX_W-1:0] IDX_ZERO = '0;
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

   typedef enum logic [1:0] {
      IDLE,
      START_BIT,
      DATA_BITS,
      STOP_BIT
   } state_t;

   state_t             state;
   state_t             state_next;
   logic [CNT_W-1:0]   bit_cnt;
   logic [CNT_W-1:0]   bit_cnt_next;
   logic [IDX_W-1:0]   bit_idx;
   logic [IDX_W-1:0]   bit_idx_next;
   logic [g_WIDTH-1:0] shift_reg;
   logic [g_WIDTH-1:0] shift_next;
   logic               serial_next;
   logic               active_next;
   logic               done_next;
   logic               bit_end;
   logic               pop;

   // The final cycle of any bit period. This is where the state moves on, or
   // where the next data bit is selected.
   assign bit_end = (bit_cnt == CNT_LAST);

   // The pop strobe is combinational. This lets the FIFO head be captured on
   // the same edge that starts the frame. Gating with i_rst keeps the strobe
   // low during reset, even though the state is already IDLE then. The
   // empty flag is also part of the gate, so an empty FIFO is never popped.
   assign pop = !i_rst && i_enable && !i_fifo_empty &&
                ((state == IDLE) || ((state == STOP_BIT) && bit_end));

   assign o_fifo_rd_en = pop;

   // Next-state logic. Defaults hold every register. Each state then only
   // describes its own changes. Once a word has been captured into
   // shift_reg, the frame runs to completion on that copy. For this reason
   // later changes on i_enable or the FIFO pins cannot disturb the frame.
   // Those inputs only matter at the decision points (IDLE and the last
   // STOP_BIT cycle).
   always_comb begin
      state_next   = state;
      bit_cnt_next = bit_cnt;
      bit_idx_next = bit_idx;
      shift_next   = shift_reg;

      unique case (state)
         IDLE: begin
            bit_cnt_next = CNT_ZERO;
            bit_idx_next = IDX_ZERO;
            if (pop) begin
               shift_next = i_fifo_rd_data;
               state_next = START_BIT;
            end
         end

         START_BIT: begin
            if (bit_end) begin
               bit_cnt_next = CNT_ZERO;
               bit_idx_next = IDX_ZERO;
               state_next   = DATA_BITS;
            end else begin
               bit_cnt_next = bit_cnt + CNT_ONE;
            end
         end

         // The shift register moves right at each data-bit boundary. This
         // keeps the bit on the line at shift_reg[0]. No variable-index mux
         // is needed.
         DATA_BITS: begin
            if (bit_end) begin
               bit_cnt_next = CNT_ZERO;
               if (bit_idx == IDX_LAST) begin
                  bit_idx_next = IDX_ZERO;
                  state_next   = STOP_BIT;
               end else begin
                  bit_idx_next = bit_idx + IDX_ONE;
                  shift_next   = {1'b0, shift_reg[g_WIDTH-1:1]};
               end
            end else begin
               bit_cnt_next = bit_cnt + CNT_ONE;
            end
         end

         // On the last stop cycle, a pop chains straight into the next start
         // bit. Back-to-back frames therefore have no idle cycle between
         // them.
         STOP_BIT: begin
            if (bit_end) begin
               bit_cnt_next = CNT_ZERO;
               if (pop) begin
                  shift_next = i_fifo_rd_data;
                  state_next = START_BIT;
               end else begin
                  state_next = IDLE;
               end
            end else begin
               bit_cnt_next = bit_cnt + CNT_ONE;
            end
         end

         default: begin
            state_next   = IDLE;
            bit_cnt_next = CNT_ZERO;
            bit_idx_next = IDX_ZERO;
         end
      endcase
   end

   // The outputs are registered. Their next values come from the next state,
   // so each registered output lines up exactly with the state it describes.
   // The line carries the start bit, the current data bit, or the idle/stop
   // high level. o_tx_done marks the final cycle of the stop bit. Because it
   // is derived from the stop-bit count, a frame cut short by reset can
   // never produce a done pulse.
   always_comb begin
      serial_next = 1'b1;
      active_next = 1'b0;
      done_next   = 1'b0;

      unique case (state_next)
         IDLE: begin
            serial_next = 1'b1;
         end
         START_BIT: begin
            serial_next = 1'b0;
            active_next = 1'b1;
         end
         DATA_BITS: begin
            serial_next = shift_next[0];
            active_next = 1'b1;
         end
         STOP_BIT: begin
            serial_next = 1'b1;
            active_next = 1'b1;
            done_next   = (bit_cnt_next == CNT_LAST);
         end
         default: begin
            serial_next = 1'b1;
         end
      endcase
   end

   // State, counters and data registers. Reset is asynchronous, so the FSM
   // returns to IDLE the instant i_rst rises, whatever the clock is doing.
   // Any word captured mid-frame is simply dropped.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state     <= IDLE;
         bit_cnt   <= CNT_ZERO;
         bit_idx   <= IDX_ZERO;
         shift_reg <= '0;
      end else begin
         state     <= state_next;
         bit_cnt   <= bit_cnt_next;
         bit_idx   <= bit_idx_next;
         shift_reg <= shift_next;
      end
   end

   // Output registers share the same asynchronous reset. The line therefore
   // goes high, and active/done go low, immediately on reset.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_tx_serial <= 1'b1;
         o_tx_active <= 1'b0;
         o_tx_done   <= 1'b0;
      end else begin
         o_tx_serial <= serial_next;
         o_tx_active <= active_next;
         o_tx_done   <= done_next;
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_fifo_uart_tx
//
// Purpose:
//    Self-checking bench for fifo_uart_tx with g_WIDTH=8, g_CLKS_PER_BIT=4.
//    A behavioural show-ahead FIFO feeds the DUT. Every byte written into
//    that FIFO is also queued as an expected frame. A monitor process
//    watches the pop strobe and compares every line cycle of each frame
//    against the queued byte.
//
// Ports:
//    none (top-level bench)
// ---------------------------------------------------------------------------
module tb_fifo_uart_tx;

   localparam int WIDTH = 8;
   localparam int CPB   = 4;
   localparam int FRAME = (WIDTH + 2) * CPB;

   logic             i_clk = 1'b0;
   logic             i_rst;
   logic             i_enable;
   logic             i_fifo_empty;
   logic [WIDTH-1:0] i_fifo_rd_data;
   logic             o_fifo_rd_en;
   logic             o_tx_serial;
   logic             o_tx_active;
   logic             o_tx_done;

   logic             clk_run = 1'b0;
   int               errors  = 0;
   int               checks  = 0;
   logic [WIDTH-1:0] fifo_q[$];
   logic [WIDTH-1:0] exp_q[$];

   fifo_uart_tx #(
      .g_WIDTH        (WIDTH),
      .g_CLKS_PER_BIT (CPB)
   ) dut (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_enable       (i_enable),
      .i_fifo_empty   (i_fifo_empty),
      .i_fifo_rd_data (i_fifo_rd_data),
      .o_fifo_rd_en   (o_fifo_rd_en),
      .o_tx_serial    (o_tx_serial),
      .o_tx_active    (o_tx_active),
      .o_tx_done      (o_tx_done)
   );

   // The clock is held still until the no-clock reset check has been made.
   initial begin
      wait (clk_run);
      forever #5 i_clk = ~i_clk;
   end

   // Safety net in case a bounded wait is ever miscounted.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Single comparison point. Every check goes through here, so the counts
   // in the summary line are exactly the comparisons made.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t",
                  name, actual, expected, $time);
      end
   endtask

   // Writes one byte into the FIFO and records the frame it must become.
   task automatic applyStimulus(input logic [WIDTH-1:0] b);
      fifo_q.push_back(b);
      exp_q.push_back(b);
   endtask

   // Show-ahead FIFO model. The pop strobe is sampled mid-cycle. The head
   // word is removed, and the FIFO pins are refreshed, shortly after the
   // next rising edge.
   initial begin
      logic pop_now;
      i_fifo_empty   = 1'b1;
      i_fifo_rd_data = '0;
      forever begin
         @(negedge i_clk);
         pop_now = o_fifo_rd_en;
         @(posedge i_clk);
         #1;
         if (pop_now && fifo_q.size() > 0) void'(fifo_q.pop_front());
         i_fifo_empty   = (fifo_q.size() == 0);
         i_fifo_rd_data = (fifo_q.size() == 0) ? '0 : fifo_q[0];
      end
   end

   // Monitor. While idle it checks the line level and the pop gating. On
   // each pop it takes the next expected byte and checks the whole
   // 40-cycle frame. Frames chain back-to-back, and reset abandons the
   // frame in flight.
   initial begin
      logic [WIDTH+1:0] frame;
      logic             exp_rd;
      bit               more;
      forever begin
         @(negedge i_clk);
         exp_rd = !i_rst && i_enable && !i_fifo_empty;
         checkOutput("idle_rd_en", o_fifo_rd_en, exp_rd);
         if (o_fifo_rd_en) begin
            more = 1'b1;
            while (more) begin
               more = 1'b0;
               checkOutput("frame_expected", exp_q.size() > 0, 1);
               if (exp_q.size() > 0) frame = {1'b1, exp_q.pop_front(), 1'b0};
               else                  frame = '0;
               for (int c = 1; c <= FRAME; c++) begin
                  @(negedge i_clk);
                  if (i_rst) break;
                  checkOutput("line_bit", o_tx_serial, frame[(c - 1) / CPB]);
                  checkOutput("active", o_tx_active, 1);
                  checkOutput("done", o_tx_done, c == FRAME);
                  checkOutput("frame_rd_en", o_fifo_rd_en,
                              (c == FRAME) && i_enable && !i_fifo_empty);
                  if (c == FRAME && o_fifo_rd_en) more = 1'b1;
               end
            end
         end else begin
            checkOutput("idle_line", o_tx_serial, 1);
            checkOutput("idle_active", o_tx_active, 0);
            checkOutput("idle_done", o_tx_done, 0);
         end
      end
   end

   // Waits for a pop, within a bounded number of cycles.
   task automatic waitPop(input int budget);
      bit seen = 1'b0;
      for (int n = 0; n < budget && !seen; n++) begin
         @(negedge i_clk);
         seen = o_fifo_rd_en;
      end
      checkOutput("pop_timeout", seen, 1);
   endtask

   // Waits until the FIFO, the scoreboard and the line are all quiet.
   task automatic waitIdle(input int budget);
      int n = 0;
      while (n < budget && !(fifo_q.size() == 0 && exp_q.size() == 0 &&
                             !o_tx_active && !o_fifo_rd_en)) begin
         @(negedge i_clk);
         n++;
      end
      checkOutput("idle_timeout", n < budget, 1);
   endtask

   initial begin
      i_rst    = 1'b1;
      i_enable = 1'b0;

      // Reset with no clock edges at all.
      #2;
      checkOutput("rst_serial", o_tx_serial, 1);
      checkOutput("rst_active", o_tx_active, 0);
      checkOutput("rst_done", o_tx_done, 0);
      checkOutput("rst_rd_en", o_fifo_rd_en, 0);

      clk_run = 1'b1;
      repeat (3) @(posedge i_clk);
      #2;
      i_rst    = 1'b0;
      i_enable = 1'b1;

      // A single frame of 0xA5.
      $display("[TB] single frame 0xA5");
      applyStimulus(8'hA5);
      waitIdle(100);

      // Three queued bytes sent back-to-back.
      $display("[TB] back-to-back 0x01 0x80 0xFF");
      applyStimulus(8'h01);
      applyStimulus(8'h80);
      applyStimulus(8'hFF);
      waitIdle(250);

      // An empty FIFO must never be popped.
      $display("[TB] empty FIFO for 200 cycles");
      for (int i = 0; i < 200; i++) begin
         @(negedge i_clk);
         checkOutput("empty_no_pop", o_fifo_rd_en, 0);
         checkOutput("empty_line", o_tx_serial, 1);
      end

      // Enable dropped mid-frame, then raised again.
      $display("[TB] enable dropped mid-frame");
      @(posedge i_clk);
      #2;
      applyStimulus(8'h5A);
      applyStimulus(8'hC3);
      waitPop(20);
      repeat (10) @(posedge i_clk);
      #2;
      i_enable = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge i_clk);
         checkOutput("disabled_no_pop", o_fifo_rd_en, 0);
      end
      checkOutput("disabled_line_idle", o_tx_active, 0);
      @(posedge i_clk);
      #2;
      i_enable = 1'b1;
      @(negedge i_clk);
      checkOutput("reenable_pop", o_fifo_rd_en, 1);
      waitIdle(100);

      // Reset pulse mid-frame, around frame cycle 15.
      $display("[TB] reset mid-frame");
      @(posedge i_clk);
      #2;
      applyStimulus(8'h3C);
      applyStimulus(8'h96);
      waitPop(20);
      repeat (15) @(posedge i_clk);
      #2;
      i_rst = 1'b1;
      #1;
      checkOutput("midrst_serial", o_tx_serial, 1);
      checkOutput("midrst_active", o_tx_active, 0);
      checkOutput("midrst_done", o_tx_done, 0);
      checkOutput("midrst_rd_en", o_fifo_rd_en, 0);
      repeat (3) @(posedge i_clk);
      #2;
      i_rst = 1'b0;
      waitIdle(150);

      checkOutput("scoreboard_drained", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 The block SHALL have parameter g_WIDTH, default 8, meaning data bits per frame, in the range 5 to 9.
REQ-002 The block SHALL have parameter g_CLKS_PER_BIT, default 87, meaning i_clk cycles per serial bit period, at least 2.
REQ-003 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-004 Port i_clk  input  1  is the single clock; all state updates occur on its rising edge.
REQ-005 Port i_rst  input  1  is the asynchronous, active-high reset.
REQ-006 Port i_enable  input  1  permits new frames to start while high.
REQ-007 Port i_fifo_empty  input  1  is the empty flag of the upstream FIFO.
REQ-008 Port i_fifo_rd_data  input  g_WIDTH  is the FIFO head word (show-ahead), valid whenever i_fifo_empty=0.
REQ-009 Port o_fifo_rd_en  output  1  pops one FIFO word in each cycle it is high.
REQ-010 Port o_tx_serial  output  1  is the UART line, idle-high.
REQ-011 Port o_tx_active  output  1  is high while a frame is on the line.
REQ-012 Port o_tx_done  output  1  is a one-cycle pulse at frame completion.

Function
REQ-013 The block SHALL implement states IDLE, START_BIT, DATA_BITS and STOP_BIT, with a bit-period counter and a data-bit index.
REQ-014 o_fifo_rd_en SHALL be high only when all of these hold: reset deasserted, i_enable=1, i_fifo_empty=0, and the state is IDLE or the last cycle of STOP_BIT; it SHALL never be high when i_fifo_empty=1.
REQ-015 In every cycle o_fifo_rd_en is high, the block SHALL capture i_fifo_rd_data into its shift register and enter START_BIT on the same edge.
REQ-016 START_BIT SHALL drive o_tx_serial=0 for exactly g_CLKS_PER_BIT cycles, then enter DATA_BITS.
REQ-017 DATA_BITS SHALL drive the captured bits LSB first, each for exactly g_CLKS_PER_BIT cycles, then enter STOP_BIT after bit g_WIDTH-1.
REQ-018 STOP_BIT SHALL drive o_tx_serial=1 for exactly g_CLKS_PER_BIT cycles.
REQ-019 On the last STOP_BIT cycle the block SHALL enter START_BIT if REQ-014 pops, otherwise IDLE.
REQ-020 Consecutive frames SHALL therefore have zero idle cycles between them.
REQ-021 A frame SHALL last (g_WIDTH+2)*g_CLKS_PER_BIT cycles, measured from the first START_BIT cycle.
REQ-022 o_tx_serial SHALL be registered, and SHALL be 1 in IDLE.
REQ-023 o_tx_active SHALL be registered, and SHALL be high in every START_BIT, DATA_BITS and STOP_BIT cycle; it stays continuously high across back-to-back frames.
REQ-024 o_tx_done SHALL be high exactly during the last STOP_BIT cycle of each frame.
REQ-025 Deasserting i_enable mid-frame SHALL NOT abort that frame; it only blocks the next pop.
REQ-026 Changes of i_fifo_rd_data or i_fifo_empty after capture SHALL NOT affect the frame in flight.
REQ-027 The counter width SHALL be $clog2(g_CLKS_PER_BIT).
REQ-028 The counter SHALL count 0 to g_CLKS_PER_BIT-1 and wrap to 0 at every bit boundary.

Reset
REQ-029 While i_rst is high, regardless of clock, the block SHALL hold: state=IDLE, o_tx_serial=1, o_tx_active=0, o_tx_done=0, o_fifo_rd_en=0, and counters and index at 0.
REQ-030 Reset mid-frame SHALL return the line high immediately, with no o_tx_done pulse; the popped byte is discarded.
REQ-031 After reset release, the block SHALL pop no earlier than the first rising edge with i_rst=0.

Verification (g_WIDTH=8, g_CLKS_PER_BIT=4)
REQ-032 Test: assert i_rst with no clock -> o_tx_serial=1, o_tx_active=0, o_tx_done=0, o_fifo_rd_en=0.
REQ-033 Test: FIFO holds 0xA5, i_enable=1 -> o_fifo_rd_en high 1 cycle; line carries 0 for 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then 1 for 4 cycles; o_tx_done pulses on cycle 40 of the frame; then IDLE.
REQ-034 Test: FIFO holds 0x01, 0x80, 0xFF -> three pops spaced exactly 40 cycles apart; 120 contiguous line cycles; o_tx_active high for all 120; three o_tx_done pulses.
REQ-035 Test: i_fifo_empty=1 for 200 cycles -> o_fifo_rd_en never high, o_tx_serial constant 1.
REQ-036 Test: two bytes queued, i_enable dropped at frame-1 cycle 10 -> frame 1 completes intact, no second pop; re-raising i_enable pops byte 2 on the next edge.
REQ-037 Test: i_rst pulsed at frame cycle 15 -> line=1 and o_tx_active=0 asynchronously, no o_tx_done; after release, the next FIFO byte is sent as a full frame.
